ledr_sequencer: RTL and testbench
=================================

# ledr_sequencer

Autonomous LED pattern sequencer that owns the Avalon-MM write port of the 10-bit LEDR PIO. The Nios configures it through a small CSR slave. The sequencer then steps through a rotate pattern or a pattern table, issuing one single-cycle PIO write per step at a programmable period. This frees the CPU from bit-banging LED animations while the VGA pipeline runs.

## Interface
Parameters:
- LED_W, 10, width of the LED pattern and of the PIO data register
- CNT_W, 24, width of the PERIOD register and period counter
- TBL_DEPTH, 8, number of pattern table entries (power of two, ≤8)

Ports:
- clk  in  1  system clock; the block uses one clock only
- reset  in  1  synchronous, active-high reset
- s_address  in  4  CSR word address
- s_chipselect  in  1  CSR select
- s_write_n  in  1  CSR write strobe, active low
- s_writedata  in  32  CSR write data
- s_readdata  out  32  CSR read data, combinational from s_address, zero-extended
- m_address  out  2  PIO address, always 0
- m_chipselect  out  1  PIO select, one-cycle pulse per step
- m_write_n  out  1  PIO write strobe, active low, asserted together with m_chipselect
- m_writedata  out  32  {(32-LED_W)'b0, pattern}
- busy  out  1  high whenever state ≠ IDLE

## Operation
- CSR map:
  - 0 CTRL: bit0 enable, bit1 mode (0 rotate, 1 table), bit2 oneshot, bit3 bounce.
  - 1 PERIOD[CNT_W-1:0]: a value of 0 is treated as 1.
  - 2 LENGTH[3:0]: 0 is treated as 1; values above TBL_DEPTH saturate to TBL_DEPTH.
  - 3 STATUS (read-only): bit0 busy, bits[6:4] current index.
  - 8..8+TBL_DEPTH-1 TABLE[i][LED_W-1:0].
  - Unmapped addresses read 0 and ignore writes.
- A CSR write occurs when s_chipselect=1 and s_write_n=0.
- FSM states are IDLE, WRITE and WAIT:
  - IDLE → WRITE when enable=1. Entry loads pattern=TABLE[0] and index=0.
  - WRITE: drive m_chipselect=1, m_write_n=0, m_writedata=pattern, then advance the step. If PERIOD>1, go to WAIT; else stay in WRITE.
  - WAIT: a timer counts PERIOD-1 cycles, then the FSM goes to WRITE.
  - Any state → IDLE on the cycle after enable is seen as 0.
- Step advance:
  - Rotate mode: pattern is rotated left by 1 within LED_W bits.
  - Table mode: index = (index+1) mod LENGTH, and pattern = TABLE[index].
  - TABLE is read at advance time, so writes made mid-run take effect on the next visit to that entry.
- Oneshot:
  - Rotate mode ends after LED_W writes. Table mode ends after LENGTH writes.
  - At the end, the hardware clears CTRL.enable and the FSM returns to IDLE.
- PERIOD written mid-run takes effect at the next WAIT entry.
- Disabling the block leaves the last written LED value in the PIO. No clearing write is issued.
- Reset: all CSRs are 0, state is IDLE, m_chipselect=0, m_write_n=1, m_address=0, m_writedata=0, busy=0.

## Timing
- Enable is written in cycle N. Busy=1 and the first write pulse occur in cycle N+1, and the PIO output updates after the edge ending N+1.
- Consecutive write pulses are exactly max(PERIOD,1) cycles apart.
- If the CSR clears enable in the same cycle the FSM is in WRITE, that pulse completes. The FSM is in IDLE the next cycle and no further pulses follow.
- If the CSR sets enable in the same cycle oneshot completion clears it, the CSR write wins and the run restarts from index 0.
- Reset asserted mid-run forces the reset values on the next edge, and any in-flight pulse is dropped.

## Configuration
- LEDR_SEQ_BOUNCE_EN defined: CTRL.bit3 is writable.
  - In table mode with bounce=1, index ping-pongs 0..LENGTH-1..0 without repeating the end entries.
  - Oneshot then ends after 2·LENGTH-1 writes (1 write when LENGTH=1).
  - Bounce is ignored in rotate mode.
- Macro undefined: CTRL.bit3 reads 0 and writes to it are ignored. The direction logic is absent.

## Structure
- Shared package ledr_seq_pkg holds:
  - the state enum (IDLE/WRITE/WAIT)
  - CSR address localparams
  - CTRL bit-index constants
- One sub-module, ledr_seq_timer, is a loadable CNT_W down-counter with load/tick/done. The top holds the CSRs, table, FSM and step logic.

## Test plan
- Reset, then read all CSRs → all 0. Also check m_chipselect=0, m_write_n=1, busy=0.
- Rotate mode, TABLE[0]=0x001, PERIOD=4, enable → writes 0x001, 0x002, 0x004… exactly 4 cycles apart, and 0x200 is followed by 0x001.
- Table mode, LENGTH=3, TABLE={0x3FF,0x155,0x2AA}, PERIOD=1, oneshot → 3 back-to-back pulses, then busy=0 and CTRL reads 0x6.
- Clear enable in the same cycle as a write pulse → that pulse completes, no further pulses follow, and the PIO holds the last value.
- PERIOD=0 and LENGTH=0 → one pulse of TABLE[0] every cycle.
- With LEDR_SEQ_BOUNCE_EN defined, LENGTH=3 and oneshot → index sequence 0,1,2,1,0 and then IDLE.

Source files
------------

// File: rtl/ledr_seq_pkg.sv
// ledr_seq_pkg: shared FSM states, CSR word addresses and CTRL bit positions for ledr_sequencer.
package ledr_seq_pkg;
  typedef enum logic [1:0] {IDLE, WRITE, WAIT} state_e;
  localparam logic [3:0] ADDR_CTRL   = 4'd0;
  localparam logic [3:0] ADDR_PERIOD = 4'd1;
  localparam logic [3:0] ADDR_LENGTH = 4'd2;
  localparam logic [3:0] ADDR_STATUS = 4'd3;
  localparam logic [3:0] ADDR_TABLE  = 4'd8;
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE    = 1;
  localparam int CTRL_ONESHOT = 2;
  localparam int CTRL_BOUNCE  = 3;
endpackage

// File: rtl/ledr_seq_timer.sv
// ledr_seq_timer: loadable down-counter; done_o flags the last cycle of a wait interval.
module ledr_seq_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [CNT_W-1:0] val_i,
  input  logic             tick_i,
  output logic             done_o
);
  logic [CNT_W-1:0] cnt_q;
  always_ff @(posedge clk)
    if (reset) cnt_q <= '0;
    else if (load_i) cnt_q <= val_i;
    else if (tick_i && cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
  assign done_o = cnt_q <= CNT_W'(1);
endmodule

// File: rtl/ledr_sequencer.sv
// ledr_sequencer: CSR-configured LED pattern sequencer driving the LEDR PIO write port.
// Define LEDR_SEQ_BOUNCE_EN to enable the table-mode ping-pong (CTRL.bounce).
module ledr_sequencer
  import ledr_seq_pkg::*;
#(
  parameter int LED_W     = 10,
  parameter int CNT_W     = 24,
  parameter int TBL_DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  s_address,
  input  logic        s_chipselect,
  input  logic        s_write_n,
  input  logic [31:0] s_writedata,
  output logic [31:0] s_readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [31:0] m_writedata,
  output logic        busy
);
  state_e state_q, state_d;
  logic [3:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_eff;
  logic [3:0] length_q, len_eff, len_m1;
  logic [LED_W-1:0] tbl_q [TBL_DEPTH];
  logic [LED_W-1:0] pattern_q, pattern_d;
  logic [2:0] index_q, index_d, step_idx;
  logic [4:0] wr_cnt_q, wr_cnt_d, wr_total;
  logic cs_q, busy_q, csr_wr, up_end, last_wr, os_done, restart, tmr_load, tmr_done, bounce;
  logic unused_ok;
  assign unused_ok = ^s_writedata[31:CNT_W];
  assign csr_wr = s_chipselect & ~s_write_n;
  assign period_eff = period_q == '0 ? CNT_W'(1) : period_q;
  assign len_eff = length_q == 4'd0 ? 4'd1 : length_q > 4'(TBL_DEPTH) ? 4'(TBL_DEPTH) : length_q;
  assign len_m1 = len_eff - 4'd1;
  assign up_end = {1'b0, index_q} >= len_m1;
`ifdef LEDR_SEQ_BOUNCE_EN
  localparam logic [3:0] CTRL_WMASK = 4'hF;
  logic dir_q, step_dir, unused_len;
  logic [3:0] len_m2;
  assign bounce = ctrl_q[CTRL_BOUNCE] & ctrl_q[CTRL_MODE];
  assign len_m2 = len_eff - 4'd2;
  assign unused_len = len_m2[3];
  // dir_q=1 walks down; the end entries are visited once per sweep
  always_comb begin
    step_dir = dir_q;
    step_idx = up_end ? 3'd0 : index_q + 3'd1;
    if (bounce && len_eff > 4'd1) begin
      step_idx = !dir_q ? (up_end ? len_m2[2:0] : index_q + 3'd1)
                        : (index_q == 3'd0 ? 3'd1 : index_q - 3'd1);
      step_dir = !dir_q ? up_end : index_q != 3'd0;
    end
  end
  always_ff @(posedge clk)
    if (reset || restart) dir_q <= 1'b0;
    else if (state_q == WRITE) dir_q <= step_dir;
`else
  localparam logic [3:0] CTRL_WMASK = 4'h7;
  assign bounce = 1'b0;
  assign step_idx = up_end ? 3'd0 : index_q + 3'd1;
`endif
  assign wr_total = !ctrl_q[CTRL_MODE] ? 5'(LED_W) : bounce ? {len_eff, 1'b0} - 5'd1 : {1'b0, len_eff};
  assign last_wr = ctrl_q[CTRL_ONESHOT] && wr_cnt_q >= wr_total - 5'd1;
  assign os_done = state_q == WRITE && last_wr;
  // a CSR write to CTRL overrides the oneshot auto-clear in the same cycle
  assign ctrl_d = csr_wr && s_address == ADDR_CTRL ? s_writedata[3:0] & CTRL_WMASK
                : {ctrl_q[3:1], ctrl_q[CTRL_EN] & ~os_done};
  assign restart = state_q == IDLE || os_done;
  always_comb begin
    state_d = state_q;
    pattern_d = pattern_q;
    index_d = index_q;
    wr_cnt_d = wr_cnt_q;
    tmr_load = 1'b0;
    if (!ctrl_d[CTRL_EN]) state_d = IDLE;
    else if (restart) begin
      state_d = WRITE;
      pattern_d = tbl_q[0];
      index_d = '0;
      wr_cnt_d = '0;
    end else if (state_q == WRITE) begin
      state_d = period_eff > CNT_W'(1) ? WAIT : WRITE;
      tmr_load = 1'b1;
      pattern_d = ctrl_q[CTRL_MODE] ? tbl_q[step_idx] : {pattern_q[LED_W-2:0], pattern_q[LED_W-1]};
      index_d = ctrl_q[CTRL_MODE] ? step_idx : index_q;
      wr_cnt_d = wr_cnt_q + {4'd0, ~&wr_cnt_q};
    end else if (state_q == WAIT && tmr_done) state_d = WRITE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ctrl_q <= '0;
      period_q <= '0;
      length_q <= '0;
      pattern_q <= '0;
      index_q <= '0;
      wr_cnt_q <= '0;
      cs_q <= 1'b0;
      busy_q <= 1'b0;
      for (int i = 0; i < TBL_DEPTH; i++) tbl_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q <= ctrl_d;
      pattern_q <= pattern_d;
      index_q <= index_d;
      wr_cnt_q <= wr_cnt_d;
      cs_q <= state_d == WRITE;
      busy_q <= state_d != IDLE;
      if (csr_wr && s_address == ADDR_PERIOD) period_q <= s_writedata[CNT_W-1:0];
      if (csr_wr && s_address == ADDR_LENGTH) length_q <= s_writedata[3:0];
      for (int i = 0; i < TBL_DEPTH; i++)
        if (csr_wr && s_address == ADDR_TABLE + 4'(i)) tbl_q[i] <= s_writedata[LED_W-1:0];
    end
  end
  ledr_seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .reset(reset),
    .load_i(tmr_load),
    .val_i(period_eff - CNT_W'(1)),
    .tick_i(state_q == WAIT),
    .done_o(tmr_done)
  );
  assign s_readdata = s_address == ADDR_CTRL ? 32'(ctrl_q)
                    : s_address == ADDR_PERIOD ? 32'(period_q)
                    : s_address == ADDR_LENGTH ? 32'(length_q)
                    : s_address == ADDR_STATUS ? 32'({index_q, 3'b000, busy_q})
                    : s_address[3] && {1'b0, s_address[2:0]} < 4'(TBL_DEPTH) ? 32'(tbl_q[s_address[2:0]])
                    : 32'd0;
  assign m_address = 2'd0;
  assign m_chipselect = cs_q;
  assign m_write_n = ~cs_q;
  assign m_writedata = 32'(pattern_q);
  assign busy = busy_q;
endmodule

// File: tb/tb_ledr_sequencer.sv
// tb_ledr_sequencer: random and directed runs checked against a pulse-schedule model of the sequencer.
module tb_ledr_sequencer;
  localparam int LED_W = 10;
`ifdef LEDR_SEQ_BOUNCE_EN
  localparam bit BEN = 1'b1;
`else
  localparam bit BEN = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1;
  logic [3:0] s_address = '0;
  logic s_chipselect = 1'b0, s_write_n = 1'b1;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata, m_writedata;
  logic [1:0] m_address;
  logic m_chipselect, m_write_n, busy;
  int n_vec = 0, n_err = 0, cyc = 0;
  int obs_t[$], obs_d[$];
  int tbl_m[8];
  logic [31:0] pio_m = '0;

  ledr_sequencer dut (
    .clk(clk), .reset(reset), .s_address(s_address), .s_chipselect(s_chipselect),
    .s_write_n(s_write_n), .s_writedata(s_writedata), .s_readdata(s_readdata),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write_n(m_write_n),
    .m_writedata(m_writedata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  // PIO model: record each write pulse and latch its data
  always @(negedge clk)
    if (!reset && m_chipselect && !m_write_n) begin
      obs_t.push_back(cyc);
      obs_d.push_back(int'(m_writedata));
      pio_m = m_writedata;
    end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic csr_write(input logic [3:0] a, input logic [31:0] d, output int wc);
    @(negedge clk);
    wc = cyc;
    s_address = a; s_writedata = d; s_chipselect = 1'b1; s_write_n = 1'b0;
    @(negedge clk);
    s_chipselect = 1'b0; s_write_n = 1'b1;
  endtask

  task automatic csr_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    s_address = a;
    #1 d = s_readdata;
  endtask

  task automatic set_tbl(input int i, input int v);
    int c;
    tbl_m[i] = v & 'h3FF;
    csr_write(4'(8 + i), 32'(tbl_m[i]), c);
  endtask

  function automatic int exp_pat(input bit mode, input int k, input int le, input bit bb);
    int r, i, m;
    if (!mode) begin
      r = k % LED_W;
      return ((tbl_m[0] << r) | (tbl_m[0] >> (LED_W - r))) & 'h3FF;
    end
    if (bb && le > 1) begin
      m = k % (2 * le - 2);
      i = m < le ? m : 2 * le - 2 - m;
    end else i = k % le;
    return tbl_m[i];
  endfunction

  task automatic run_scn(input bit mode, input bit os, input bit bnc, input int per, input int len, input int ncyc);
    int c, d, pe, le, tot, n, ec;
    logic [31:0] r;
    bit bb;
    pe = per == 0 ? 1 : per;
    le = len == 0 ? 1 : (len > 8 ? 8 : len);
    bb = BEN && bnc && mode;
    tot = !mode ? LED_W : (bb ? 2 * le - 1 : le);
    ec = (BEN && bnc ? 8 : 0) + (os ? 4 : 0) + (mode ? 2 : 0);
    csr_write(4'd1, 32'(per), c);
    csr_write(4'd2, 32'(len), c);
    obs_t.delete(); obs_d.delete();
    csr_write(4'd0, 32'({bnc, os, mode, 1'b1}), c);
    check("busy_on", 32'(busy), 1);
    repeat (ncyc) @(negedge clk);
    if (os) begin
      csr_read(4'd0, r);
      check("ctrl_after_oneshot", r, 32'(ec));
    end
    csr_write(4'd0, 32'd0, d);
    repeat (3) @(negedge clk);
    n = 0;
    while (c + 1 + n * pe <= d && !(os && n >= tot)) n++;
    check("pulse_count", 32'(obs_t.size()), 32'(n));
    for (int k = 0; k < n && k < obs_t.size(); k++) begin
      check($sformatf("pulse%0d_cycle", k), 32'(obs_t[k]), 32'(c + 1 + k * pe));
      check($sformatf("pulse%0d_data", k), 32'(obs_d[k]), 32'(exp_pat(mode, k, le, bb)));
    end
    check("busy_off", 32'(busy), 0);
    check("pio_hold", pio_m, 32'(exp_pat(mode, n - 1, le, bb)));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    int c;
    bit md, os, bn;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int a = 0; a < 16; a++) begin
      csr_read(4'(a), r);
      check($sformatf("reset_csr%0d", a), r, 0);
    end
    check("reset_cs", 32'(m_chipselect), 0);
    check("reset_wn", 32'(m_write_n), 1);
    check("reset_busy", 32'(busy), 0);
    check("reset_addr", 32'(m_address), 0);
    check("reset_wdata", m_writedata, 0);
    csr_write(4'd5, 32'hFFFF, c);
    csr_read(4'd5, r);
    check("unmapped", r, 0);
    csr_write(4'd0, 32'h8, c);
    csr_read(4'd0, r);
    check("bounce_bit", r, BEN ? 32'h8 : 32'h0);
    csr_write(4'd0, 32'h0, c);
    set_tbl(0, 'h001);
    run_scn(1'b0, 1'b0, 1'b0, 4, 0, 50);
    set_tbl(0, 'h3FF); set_tbl(1, 'h155); set_tbl(2, 'h2AA);
    run_scn(1'b1, 1'b1, 1'b0, 1, 3, 10);
    run_scn(1'b1, 1'b0, 1'b0, 0, 0, 8);
    run_scn(1'b1, 1'b1, 1'b1, 1, 3, 15);
    run_scn(1'b0, 1'b1, 1'b0, 2, 0, 30);
    for (int t = 0; t < 14; t++) begin
      for (int i = 0; i < 8; i++) set_tbl(i, int'($urandom));
      md = 1'($urandom); os = 1'($urandom); bn = 1'($urandom);
      run_scn(md, os, bn, int'($urandom_range(0, 5)), int'($urandom_range(0, 10)),
              os ? 60 : int'($urandom_range(3, 30)));
    end
    csr_write(4'd1, 32'd1, c);
    csr_write(4'd0, 32'h1, c);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_reset_cs", 32'(m_chipselect), 0);
    check("midrun_reset_wn", 32'(m_write_n), 1);
    check("midrun_reset_busy", 32'(busy), 0);
    check("midrun_reset_wdata", m_writedata, 0);
    reset = 1'b0;
    csr_read(4'd0, r);
    check("midrun_reset_ctrl", r, 0);
    csr_read(4'd8, r);
    check("midrun_reset_tbl0", r, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
